// File: rtl/quad_mixer_if.sv
// LO sample / mixer product bus of quad_mixer. The master drives the NCO samples in
// and receives the I/Q products. The slave is the mixer itself.
interface quad_mixer_if #(
    parameter int LO_WIDTH  = 12,
    parameter int OUT_WIDTH = 12
) ();
    logic                        lo_valid;
    logic signed [LO_WIDTH-1:0]  sin_in;
    logic signed [LO_WIDTH-1:0]  cos_in;
    logic                        mix_valid;
    logic signed [OUT_WIDTH-1:0] mix_sin;
    logic signed [OUT_WIDTH-1:0] mix_cos;

    modport master (
        output lo_valid, sin_in, cos_in,
        input  mix_valid, mix_sin, mix_cos
    );

    modport slave (
        input  lo_valid, sin_in, cos_in,
        output mix_valid, mix_sin, mix_cos
    );
endinterface

// File: rtl/quad_mixer.sv
// Quadrature mixer: synchronised RF sample times NCO sin/cos, scaled and saturated to OUT_WIDTH.
// Optional build macro QUAD_MIXER_ROUND_EN selects round-half-up scaling instead of truncation.
module quad_mixer #(
    parameter int LO_WIDTH    = 12,
    parameter int RF_WIDTH    = 1,
    parameter int OUT_WIDTH   = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [RF_WIDTH-1:0] rf_in,
    output logic [RF_WIDTH-1:0] rf_out,
    input  logic                clear_sat,
    output logic [15:0]         sat_count,
    quad_mixer_if.slave         mix_bus
);

    localparam int PW = LO_WIDTH + RF_WIDTH;
    localparam int SH = RF_WIDTH - 1;
    localparam int SW = PW + 1;
    localparam int CW = ((SW > OUT_WIDTH) ? SW : OUT_WIDTH) + 1;
    localparam logic [RF_WIDTH-1:0] RF_RST = RF_WIDTH'(RF_WIDTH == 1);
    localparam logic signed [CW-1:0] SAT_MAX =
        {{(CW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [CW-1:0] SAT_MIN =
        {{(CW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
`ifdef QUAD_MIXER_ROUND_EN
    localparam int RND_SH = (SH > 0) ? SH - 1 : 0;
    localparam logic signed [SW-1:0] RND = (SH > 0) ? (SW'(1) << RND_SH) : SW'(0);
`endif

    // A 1-bit comparator sample means sign flip; wider samples are true signed multiplies.
    function automatic logic signed [PW-1:0] mult(input logic [RF_WIDTH-1:0] rf,
                                                  input logic signed [LO_WIDTH-1:0] lo);
        logic signed [PW-1:0] lo_x;
        logic signed [PW-1:0] rf_x;
        lo_x = PW'(lo);
        rf_x = PW'($signed(rf));
        if (RF_WIDTH == 1) begin
            mult = rf[0] ? -lo_x : lo_x;
        end else begin
            mult = rf_x * lo_x;
        end
    endfunction

    // One extra bit so the rounding offset can never wrap before saturation.
    function automatic logic signed [SW-1:0] scale(input logic signed [PW-1:0] p);
        logic signed [SW-1:0] px;
        px = SW'(p);
`ifdef QUAD_MIXER_ROUND_EN
        px = px + RND;
`else
        px = px;
`endif
        scale = px >>> SH;
    endfunction

    // Returns {clamped, value}.
    function automatic logic [OUT_WIDTH:0] saturate(input logic signed [SW-1:0] s);
        logic signed [CW-1:0] w;
        w = CW'(s);
        if (w > SAT_MAX) begin
            saturate = {1'b1, SAT_MAX[OUT_WIDTH-1:0]};
        end else if (w < SAT_MIN) begin
            saturate = {1'b1, SAT_MIN[OUT_WIDTH-1:0]};
        end else begin
            saturate = {1'b0, w[OUT_WIDTH-1:0]};
        end
    endfunction

    logic [RF_WIDTH-1:0]         sync_q [SYNC_STAGES];
    logic [RF_WIDTH-1:0]         sync_d [SYNC_STAGES];
    logic [RF_WIDTH-1:0]         rf_s;

    logic                        vld_p1_q, vld_p1_d;
    logic signed [PW-1:0]        prod_sin_p1_q, prod_sin_p1_d;
    logic signed [PW-1:0]        prod_cos_p1_q, prod_cos_p1_d;

    logic                        mix_valid_q, mix_valid_d;
    logic signed [OUT_WIDTH-1:0] mix_sin_q, mix_sin_d;
    logic signed [OUT_WIDTH-1:0] mix_cos_q, mix_cos_d;
    logic [15:0]                 sat_count_q, sat_count_d;
    logic [OUT_WIDTH:0]          sat_sin, sat_cos;
    logic                        sat_event;

    // RF synchroniser
    always_comb begin
        for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_d[i] = (i == 0) ? rf_in : sync_q[(i == 0) ? 0 : i - 1];
        end
    end

    assign rf_s   = sync_q[SYNC_STAGES-1];
    assign rf_out = sync_q[0];

    // Stage 1: raw product, captured only for valid LO samples
    always_comb begin
        vld_p1_d      = mix_bus.lo_valid;
        prod_sin_p1_d = prod_sin_p1_q;
        prod_cos_p1_d = prod_cos_p1_q;
        if (mix_bus.lo_valid) begin
            prod_sin_p1_d = mult(rf_s, mix_bus.sin_in);
            prod_cos_p1_d = mult(rf_s, mix_bus.cos_in);
        end
    end

    // Stage 2: scale, saturate, count clamp events
    always_comb begin
        sat_sin     = saturate(scale(prod_sin_p1_q));
        sat_cos     = saturate(scale(prod_cos_p1_q));
        sat_event   = vld_p1_q & (sat_sin[OUT_WIDTH] | sat_cos[OUT_WIDTH]);
        mix_valid_d = vld_p1_q;
        mix_sin_d   = mix_sin_q;
        mix_cos_d   = mix_cos_q;
        if (vld_p1_q) begin
            mix_sin_d = sat_sin[OUT_WIDTH-1:0];
            mix_cos_d = sat_cos[OUT_WIDTH-1:0];
        end
        sat_count_d = sat_count_q;
        if (clear_sat) begin
            sat_count_d = 16'h0000;
        end else if (sat_event && (sat_count_q != 16'hFFFF)) begin
            sat_count_d = sat_count_q + 16'h0001;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= RF_RST;
            end
            vld_p1_q      <= 1'b0;
            prod_sin_p1_q <= '0;
            prod_cos_p1_q <= '0;
            mix_valid_q   <= 1'b0;
            mix_sin_q     <= '0;
            mix_cos_q     <= '0;
            sat_count_q   <= 16'h0000;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            vld_p1_q      <= vld_p1_d;
            prod_sin_p1_q <= prod_sin_p1_d;
            prod_cos_p1_q <= prod_cos_p1_d;
            mix_valid_q   <= mix_valid_d;
            mix_sin_q     <= mix_sin_d;
            mix_cos_q     <= mix_cos_d;
            sat_count_q   <= sat_count_d;
        end
    end

    assign mix_bus.mix_valid = mix_valid_q;
    assign mix_bus.mix_sin   = mix_sin_q;
    assign mix_bus.mix_cos   = mix_cos_q;
    assign sat_count         = sat_count_q;

endmodule
